// File: rtl/tiny_fpga_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : tiny_fpga_cfg_loader_if
// Brief    : AXI-stream style bitstream beat channel for the config loader.
// Revision : 1.0
// ============================================================================
interface tiny_fpga_cfg_loader_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  s_tvalid;
    logic                  s_tready;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tlast;

    modport master (output s_tvalid, s_tdata, s_tlast, input  s_tready);
    modport slave  (input  s_tvalid, s_tdata, s_tlast, output s_tready);
endinterface
`default_nettype wire

// File: rtl/tiny_fpga_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tiny_fpga_cfg_loader
// Brief    : Packs stream beats MSB-first into a CFG_BITS image with framing
//            checks; optional CRC-8 trailer via TINY_FPGA_CFG_CRC_EN.
// Revision : 1.0
// ============================================================================
module tiny_fpga_cfg_loader #(
    parameter int DATA_WIDTH = 1,
    parameter int CFG_BITS   = 64
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              cfg,
    tiny_fpga_cfg_loader_if.slave  s_axis,
    output logic [CFG_BITS-1:0]    cfg_bits,
    output logic                   cfg_valid,
    output logic                   busy,
    output logic [1:0]             err_code
);

`ifdef TINY_FPGA_CFG_CRC_EN
    localparam int c_STREAM_BITS = CFG_BITS + 8;
`else
    localparam int c_STREAM_BITS = CFG_BITS;
`endif
    localparam int c_BEATS = c_STREAM_BITS / DATA_WIDTH;
    localparam int c_CNT_W = $clog2(c_BEATS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(c_BEATS - 1);

    generate
        if (DATA_WIDTH < 1 || (c_STREAM_BITS % DATA_WIDTH) != 0) begin : g_bad_width
            $error("tiny_fpga_cfg_loader: stream length must be a multiple of DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_cfg_q;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [1:0]            w_err_next;
    logic                  w_cfg_start;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_load_beat;
    logic                  w_next_busy;
    logic                  w_crc_ok;
    logic [CFG_BITS-1:0]   w_img;

    assign w_cfg_start = cfg & ~r_cfg_q;
    assign w_accept    = s_axis.s_tvalid & s_axis.s_tready;
    assign w_last_beat = (r_cnt == c_LAST_IDX);
    // A restart in the same cycle as a handshake drops that beat.
    assign w_load_beat = (r_state == S_LOAD) & w_accept & ~w_cfg_start;
    assign w_next_busy = (w_next_state == S_LOAD) || (w_next_state == S_DRAIN);

    always_comb begin
        w_img = cfg_bits;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
`ifdef TINY_FPGA_CFG_CRC_EN
            // Trailing CRC bits run through the checker but never reach the image.
            if ((int'(r_cnt) * DATA_WIDTH) + (DATA_WIDTH - 1 - i) < CFG_BITS)
`endif
                w_img = (w_img << 1) | CFG_BITS'(s_axis.s_tdata[i]);
        end
    end

`ifdef TINY_FPGA_CFG_CRC_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_next;

    always_comb begin
        w_crc_next = r_crc;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            w_crc_next = {w_crc_next[6:0], 1'b0}
                       ^ ((w_crc_next[7] ^ s_axis.s_tdata[i]) ? 8'h07 : 8'h00);
        end
    end

    assign w_crc_ok = (w_crc_next == 8'h00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crc <= 8'h00;
        end else if (w_cfg_start) begin
            r_crc <= 8'h00;
        end else if (w_load_beat) begin
            r_crc <= w_crc_next;
        end
    end
`else
    assign w_crc_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_err_next   = err_code;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_cfg_start) begin
                    w_next_state = S_LOAD;
                    w_err_next   = 2'b00;
                end
            end
            S_LOAD: begin
                if (w_cfg_start) begin
                    w_next_state = S_LOAD;
                    w_err_next   = 2'b00;
                end else if (w_accept) begin
                    if (w_last_beat && s_axis.s_tlast) begin
                        if (w_crc_ok) begin
                            w_next_state = S_DONE;
                        end else begin
                            w_next_state = S_IDLE;
                            w_err_next   = 2'b11;
                        end
                    end else if (w_last_beat) begin
                        w_next_state = S_DRAIN;
                        w_err_next   = 2'b10;
                    end else if (s_axis.s_tlast) begin
                        w_next_state = S_IDLE;
                        w_err_next   = 2'b01;
                    end
                end
            end
            S_DRAIN: begin
                if (w_cfg_start) begin
                    w_next_state = S_LOAD;
                    w_err_next   = 2'b00;
                end else if (w_accept && s_axis.s_tlast) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg_q         <= 1'b0;
            r_cnt           <= '0;
            cfg_bits        <= '0;
            cfg_valid       <= 1'b0;
            err_code        <= 2'b00;
            busy            <= 1'b0;
            s_axis.s_tready <= 1'b0;
        end else begin
            r_cfg_q         <= cfg;
            err_code        <= w_err_next;
            cfg_valid       <= (w_next_state == S_DONE);
            busy            <= w_next_busy;
            s_axis.s_tready <= w_next_busy;
            if (w_cfg_start) begin
                r_cnt <= '0;
            end else if (w_load_beat) begin
                cfg_bits <= w_img;
                r_cnt    <= r_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tiny_fpga_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiny_fpga_cfg_loader
// Brief    : Self-checking bench for tiny_fpga_cfg_loader (CRC build via
//            TINY_FPGA_CFG_CRC_EN switches to 8-bit beats).
// Revision : 1.0
// ============================================================================
module tb_tiny_fpga_cfg_loader;

    localparam int CB = 16;
`ifdef TINY_FPGA_CFG_CRC_EN
    localparam int DW    = 8;
    localparam int BEATS = (CB + 8) / DW;
`else
    localparam int DW    = 4;
    localparam int BEATS = CB / DW;
`endif
    localparam int OW = CB + 5;

    logic          clk;
    logic          rst_n;
    logic          cfg;
    logic [CB-1:0] cfg_bits;
    logic          cfg_valid;
    logic          busy;
    logic [1:0]    err_code;

    int checks   = 0;
    int failures = 0;

    // Behavioural expectation state
    logic [CB-1:0] exp_img;
    logic          exp_valid;
    logic [1:0]    exp_err;
    logic [DW-1:0] beat_q[$];

    logic [OW-1:0] obs;
    logic [OW-1:0] exp_v;

    tiny_fpga_cfg_loader_if #(.DATA_WIDTH(DW)) s_axis ();

    tiny_fpga_cfg_loader #(
        .DATA_WIDTH (DW),
        .CFG_BITS   (CB)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (cfg),
        .s_axis    (s_axis),
        .cfg_bits  (cfg_bits),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cfg();
        cfg = 1'b1;
        step();
        cfg = 1'b0;
    endtask

    // Remainder of an nbits-long bit string modulo x^8+x^2+x+1.
    function automatic logic [7:0] poly_mod(input logic [63:0] v, input int nbits);
        logic [63:0] r;
        r = v;
        for (int b = nbits - 1; b >= 8; b--) begin
            if (r[b]) r = r ^ (64'h107 << (b - 8));
        end
        return r[7:0];
    endfunction

    // Expected outcome of streaming beat_q (tlast on its last entry).
    task automatic model_run();
        int n;
        int take;
        logic [63:0] stream;
        n      = beat_q.size();
        take   = (n < BEATS) ? n : BEATS;
        stream = '0;
        for (int k = 0; k < take; k++) begin
            stream = (stream << DW) | 64'(beat_q[k]);
            if (k * DW < CB) exp_img = (exp_img << DW) | CB'(beat_q[k]);
        end
        if (n < BEATS)      exp_err = 2'b01;
        else if (n > BEATS) exp_err = 2'b10;
`ifdef TINY_FPGA_CFG_CRC_EN
        else if (poly_mod(stream, BEATS * DW) != 8'h00) exp_err = 2'b11;
`endif
        else exp_err = 2'b00;
        exp_valid = (exp_err == 2'b00);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input bit gaps);
        bit hs;
        int n;
        if (gaps) begin
            while ($urandom_range(0, 99) < 30) begin
                s_axis.s_tvalid = 1'b0;
                step();
            end
        end
        s_axis.s_tvalid = 1'b1;
        s_axis.s_tdata  = d;
        s_axis.s_tlast  = last;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            hs = s_axis.s_tready;
            step();
            n++;
        end
        s_axis.s_tvalid = 1'b0;
        s_axis.s_tlast  = 1'b0;
        if (!hs) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: beat %h not accepted within 50 cycles", d);
        end
    endtask

    task automatic send_queue(input bit gaps);
        for (int k = 0; k < beat_q.size(); k++) begin
            send_beat(beat_q[k], (k == beat_q.size() - 1), gaps);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        exp_img = '0;
        checks++;
        if (cfg_bits !== '0) begin
            failures++;
            $display("FAIL reset_cfg_bits: got %h want 0", cfg_bits);
        end
        obs = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        checks++;
        if (obs[4:0] !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000", obs[4:0]);
        end
    endtask

`ifndef TINY_FPGA_CFG_CRC_EN
    task automatic test_nominal();
        pulse_cfg();
        obs = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        checks++;
        if (obs[4:0] !== 5'b0_00_11) begin
            failures++;
            $display("FAIL nominal_start: got flags %b want 00011", obs[4:0]);
        end
        send_beat(4'hA, 1'b0, 1'b0);
        send_beat(4'hB, 1'b0, 1'b0);
        send_beat(4'hC, 1'b0, 1'b0);
        checks++;
        if (cfg_valid !== 1'b0) begin
            failures++;
            $display("FAIL nominal_early_valid: got %b want 0", cfg_valid);
        end
        send_beat(4'hD, 1'b1, 1'b0);
        exp_img = 16'hABCD;
        obs     = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        exp_v   = {16'hABCD, 1'b1, 2'b00, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL nominal_done: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_short();
        beat_q = '{4'h1, 4'h2};
        model_run();
        pulse_cfg();
        send_queue(1'b0);
        obs   = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        exp_v = {exp_img, 1'b0, 2'b01, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL short_frame: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_long();
        pulse_cfg();
        for (int k = 0; k < 4; k++) send_beat(4'(k + 5), 1'b0, 1'b0);
        exp_img = 16'h5678;
        obs     = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        exp_v   = {16'h5678, 1'b0, 2'b10, 1'b1, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL long_drain_entry: got %h want %h", obs, exp_v);
        end
        send_beat(4'h9, 1'b0, 1'b0);
        send_beat(4'hA, 1'b1, 1'b0);
        obs   = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        exp_v = {16'h5678, 1'b0, 2'b10, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL long_drain_exit: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_restart();
        pulse_cfg();
        send_beat(4'hE, 1'b0, 1'b0);
        send_beat(4'hF, 1'b0, 1'b0);
        s_axis.s_tvalid = 1'b1;
        s_axis.s_tdata  = 4'h7;
        cfg             = 1'b1;
        step();
        s_axis.s_tvalid = 1'b0;
        cfg             = 1'b0;
        obs = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        checks++;
        if (obs[4:0] !== 5'b0_00_11) begin
            failures++;
            $display("FAIL restart_state: got flags %b want 00011", obs[4:0]);
        end
        beat_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        send_queue(1'b0);
        exp_img = 16'h1234;
        obs     = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        exp_v   = {16'h1234, 1'b1, 2'b00, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL restart_reload: got %h want %h", obs, exp_v);
        end
    endtask
`endif

`ifdef TINY_FPGA_CFG_CRC_EN
    task automatic test_crc();
        logic [7:0] crc;
        crc = poly_mod({40'h0, 16'h1234, 8'h00}, 24);
        beat_q = '{8'h12, 8'h34, crc};
        model_run();
        pulse_cfg();
        send_queue(1'b0);
        obs   = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        exp_v = {16'h1234, 1'b1, 2'b00, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL crc_good: got %h want %h", obs, exp_v);
        end
        beat_q = '{8'h12, 8'h34, crc ^ 8'h01};
        model_run();
        pulse_cfg();
        send_queue(1'b0);
        obs   = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        exp_v = {16'h1234, 1'b0, 2'b11, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL crc_bad: got %h want %h", obs, exp_v);
        end
    endtask
`endif

    task automatic test_random_gaps();
        int n;
        logic [63:0] stream;
        for (int it = 0; it < 12; it++) begin
            n = ($urandom_range(0, 1) == 0) ? BEATS : int'($urandom_range(1, BEATS + 2));
            beat_q = {};
            for (int k = 0; k < n; k++) beat_q.push_back(DW'($urandom));
`ifdef TINY_FPGA_CFG_CRC_EN
            if (n == BEATS && $urandom_range(0, 2) != 0) begin
                stream = '0;
                for (int k = 0; k < BEATS - 1; k++) stream = (stream << DW) | 64'(beat_q[k]);
                beat_q[BEATS-1] = poly_mod(stream << 8, BEATS * DW);
            end
`else
            stream = '0;
`endif
            model_run();
            pulse_cfg();
            send_queue(1'b1);
            obs   = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
            exp_v = {exp_img, exp_valid, exp_err, 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random_load[%0d] n=%0d: got %h want %h", it, n, obs, exp_v);
            end
        end
    endtask

    task automatic test_hold_cfg();
        beat_q = {};
        for (int k = 0; k < BEATS; k++) beat_q.push_back(DW'($urandom));
`ifdef TINY_FPGA_CFG_CRC_EN
        beat_q[BEATS-1] = poly_mod({40'h0, beat_q[0], beat_q[1], 8'h00}, 24);
`endif
        model_run();
        cfg = 1'b1;
        step();
        send_queue(1'b0);
        repeat (5) step();
        obs   = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        exp_v = {exp_img, 1'b1, 2'b00, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL hold_cfg_no_reload: got %h want %h", obs, exp_v);
        end
        cfg = 1'b0;
        step();
    endtask

    task automatic test_reset_midload();
        pulse_cfg();
        send_beat(DW'($urandom), 1'b0, 1'b0);
        send_beat(DW'($urandom), 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        exp_img = '0;
        obs     = {cfg_bits, cfg_valid, err_code, busy, s_axis.s_tready};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_midload: got %h want 0", obs);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        cfg             = 1'b0;
        s_axis.s_tvalid = 1'b0;
        s_axis.s_tdata  = '0;
        s_axis.s_tlast  = 1'b0;
        exp_img         = '0;
        exp_valid       = 1'b0;
        exp_err         = 2'b00;
        test_reset();
`ifndef TINY_FPGA_CFG_CRC_EN
        test_nominal();
        test_short();
        test_long();
        test_restart();
`else
        test_crc();
`endif
        test_random_gaps();
        test_hold_cfg();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
